// File: rtl/div3_seq_16.sv
`default_nettype none
// ============================================================================
// Module   : div3_seq_16
// Purpose  : Sequential divide-by-3, two dividend bits per cycle, valid/ready
//            handshake. Optional remainder port under macro DIV3_REM_OUT_EN.
// Revision : 1.0
// ============================================================================
module div3_seq_16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q
`ifdef DIV3_REM_OUT_EN
    ,
    output logic [1:0]   r
`endif
);

    localparam int CW = $clog2(W/2);

    localparam logic [1:0]    c_ST_IDLE  = 2'd0;
    localparam logic [1:0]    c_ST_RUN   = 2'd1;
    localparam logic [1:0]    c_ST_DONE  = 2'd2;
    localparam logic [CW-1:0] c_CNT_LOAD = CW'(W/2 - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  dvd_q,   dvd_d;
    logic [W-3:0]  quo_q,   quo_d;
    logic [1:0]    rem_q,   rem_d;
    logic [W-1:0]  q_q,     q_d;
`ifdef DIV3_REM_OUT_EN
    logic [1:0]    r_q,     r_d;
`endif

    logic [3:0]    w_lut;
    logic [1:0]    w_digit;
    logic [1:0]    w_rem;
    logic [W-1:0]  w_quo_step;

    // t = 4*rem + d lies in 0..11; result packs {t/3, t%3}
    function automatic logic [3:0] div3_lut(input logic [3:0] t);
        logic [3:0] res;
        case (t)
            4'd0:    res = {2'd0, 2'd0};
            4'd1:    res = {2'd0, 2'd1};
            4'd2:    res = {2'd0, 2'd2};
            4'd3:    res = {2'd1, 2'd0};
            4'd4:    res = {2'd1, 2'd1};
            4'd5:    res = {2'd1, 2'd2};
            4'd6:    res = {2'd2, 2'd0};
            4'd7:    res = {2'd2, 2'd1};
            4'd8:    res = {2'd2, 2'd2};
            4'd9:    res = {2'd3, 2'd0};
            4'd10:   res = {2'd3, 2'd1};
            4'd11:   res = {2'd3, 2'd2};
            default: res = 4'd0;
        endcase
        return res;
    endfunction

    assign w_lut      = div3_lut({rem_q, dvd_q[W-1:W-2]});
    assign w_digit    = w_lut[3:2];
    assign w_rem      = w_lut[1:0];
    assign w_quo_step = {quo_q, w_digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (in_valid)        state_d = c_ST_RUN;
            c_ST_RUN:  if (cnt_q == '0)     state_d = c_ST_DONE;
            c_ST_DONE: if (out_ready)       state_d = c_ST_IDLE;
            default:                        state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == c_ST_IDLE);
        out_valid = (state_q == c_ST_DONE);
    end

    always_comb begin
        cnt_d = cnt_q;
        dvd_d = dvd_q;
        quo_d = quo_q;
        rem_d = rem_q;
        q_d   = q_q;
`ifdef DIV3_REM_OUT_EN
        r_d   = r_q;
`endif
        case (state_q)
            c_ST_IDLE: begin
                if (in_valid) begin
                    dvd_d = x;
                    quo_d = '0;
                    rem_d = 2'd0;
                    cnt_d = c_CNT_LOAD;
                end
            end
            c_ST_RUN: begin
                dvd_d = {dvd_q[W-3:0], 2'b00};
                quo_d = w_quo_step[W-3:0];
                rem_d = w_rem;
                if (cnt_q == '0) begin
                    q_d = w_quo_step;
`ifdef DIV3_REM_OUT_EN
                    r_d = w_rem;
`endif
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dvd_q <= '0;
            quo_q <= '0;
            rem_q <= 2'd0;
            q_q   <= '0;
`ifdef DIV3_REM_OUT_EN
            r_q   <= 2'd0;
`endif
        end else begin
            cnt_q <= cnt_d;
            dvd_q <= dvd_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            q_q   <= q_d;
`ifdef DIV3_REM_OUT_EN
            r_q   <= r_d;
`endif
        end
    end

    assign q = q_q;
`ifdef DIV3_REM_OUT_EN
    assign r = r_q;
`endif

endmodule
`default_nettype wire
